// File: rtl/face_detect_mac_ctrl.sv
// face_detect_mac_ctrl: operand feed and per-feature accumulate stage around a ce-gated pipelined multiplier.
// Optional macro FD_MAC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
`default_nettype none

module face_detect_mac_ctrl #(
  parameter int A_W     = 16,
  parameter int B_W     = 6,
  parameter int P_W     = 21,
  parameter int MUL_LAT = 3,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_last,
  output logic             mul_ce,
  output logic [A_W-1:0]   mul_din0,
  output logic [B_W-1:0]   mul_din1,
  input  logic [P_W-1:0]   mul_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  logic               stall;
  logic [MUL_LAT-1:0] vld;
  logic [MUL_LAT-1:0] lst;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic               consume;
  logic               grp_last;
  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     sum_ext;
  logic               ovf_next;
  logic [ACC_W-1:0]   sum_res;
  logic [CNT_W-1:0]   cnt_next;

  // A held result freezes the multiplier and the feed, so nothing needs a skid buffer.
  assign stall    = out_valid & ~out_ready;
  assign mul_ce   = ~stall;
  assign in_ready = ~stall;
  assign mul_din0 = in_a;
  assign mul_din1 = in_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      lst <= '0;
    end else if (mul_ce) begin
      vld[0] <= in_valid & in_ready;
      lst[0] <= in_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  assign consume  = mul_ce & vld[MUL_LAT-1];
  assign grp_last = lst[MUL_LAT-1];

  always_comb begin
    prod_ext           = '0;
    prod_ext[P_W-1:0]  = mul_dout;
    sum_ext            = {1'b0, acc} + prod_ext;
    ovf_next           = ovf | sum_ext[ACC_W];
`ifdef FD_MAC_SAT_EN
    // Once the group has overflowed, stay pinned at full scale.
    sum_res            = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    sum_res            = sum_ext[ACC_W-1:0];
`endif
    cnt_next           = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (consume) begin
      if (grp_last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= sum_res;
        cnt <= cnt_next;
        ovf <= ovf_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (consume && grp_last) begin
      out_valid <= 1'b1;
      out_sum   <= sum_res;
      out_cnt   <= cnt_next;
      out_ovf   <= ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
